count_bcd_display: RTL and testbench

Display back-end for the 8-bit up/down counter. It consumes the counter's `count` bus and converts it to three BCD digits using a sequential shift-and-add-3 (double-dabble) engine. It then time-multiplexes the digits onto a single common 7-segment bus. It sits directly downstream of the counter and drives the board's 3-digit display.

---
 rtl/count_bcd_display.sv | 154 +++++++++++++++
 tb/tb_count_bcd_display.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/count_bcd_display.sv
// Counter display back-end: sequential double-dabble binary->BCD plus a 3-digit
// multiplexed 7-segment scanner. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module count_bcd_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  last_q, last_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;
  logic [11:0] adj;

  logic [PW-1:0] prescale_q, prescale_d;
  logic [1:0]    idx_q, idx_d;

  always_comb begin
    // add-3 correction on every BCD nibble before the shift
    adj = sr_q[19:8];
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr_q[8 + 4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = sr_q[8 + 4*i +: 4] + 4'd3;
    end

    state_d  = state_q;
    last_d   = last_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    bcd_d    = bcd_q;

    case (state_q)
      S_IDLE: begin
        if (count != last_q) begin
          sr_d     = {12'h000, count};
          last_d   = count;
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d     = {adj, sr_q[7:0]} << 1;
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7)
          state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = sr_q[19:8];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= '0;
      sr_q     <= '0;
      bitcnt_q <= '0;
      bcd_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      bcd_q    <= bcd_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    prescale_d = prescale_q + PW'(1);
    idx_d      = idx_q;
    if (prescale_q == PW'(SCAN_DIV - 1)) begin
      prescale_d = '0;
      idx_d      = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
      idx_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      idx_q      <= idx_d;
    end
  end

  logic [3:0] digit;
  logic       blank;

  always_comb begin
    case (idx_q)
      2'd1:    an = 3'b010;
      2'd2:    an = 3'b100;
      default: an = 3'b001;
    endcase

    case (idx_q)
      2'd1:    digit = bcd_q[7:4];
      2'd2:    digit = bcd_q[11:8];
      default: digit = bcd_q[3:0];
    endcase

    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q == 2'd2 && bcd_q[11:8] == 4'd0)
      blank = 1'b1;
    if (idx_q == 2'd1 && bcd_q[11:4] == 8'd0)
      blank = 1'b1;
`endif

    case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    if (blank)
      seg = 7'b0000000;
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: decimal-arithmetic reference model checked every
// cycle, plus literal expectations for reset, conversions, scanning and blanking.
module tb_count_bcd_display;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  count = 8'd0;
  logic [11:0] bcd;
  logic        busy;
  logic [2:0]  an;
  logic [6:0]  seg;

  count_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .bcd   (bcd),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
    seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
    seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1111011;
  end

  // Model: remaining busy cycles, last accepted value, displayed decimal value.
  int m_last = 0, m_pend = 0, m_rem = 0, m_val = 0, m_t = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_last = 0; m_pend = 0; m_rem = 0; m_val = 0; m_t = 0;
    end else begin
      m_t++;
      if (m_rem == 0) begin
        if (int'(count) != m_last) begin
          m_last = int'(count);
          m_pend = int'(count);
          m_rem  = 9;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_val = m_pend;
      end
    end
  end

  function automatic logic [11:0] exp_bcd();
    return {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10)};
  endfunction

  function automatic int exp_idx();
    return (m_t / SCAN_DIV) % 3;
  endfunction

  function automatic logic [6:0] exp_seg();
    int h, t, u, d, i;
    h = m_val / 100; t = (m_val / 10) % 10; u = m_val % 10;
    i = exp_idx();
    d = (i == 0) ? u : (i == 1) ? t : h;
`ifdef LEADING_ZERO_BLANK_EN
    if (i == 2 && h == 0) return 7'b0000000;
    if (i == 1 && h == 0 && t == 0) return 7'b0000000;
`endif
    return seg_tab[d];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      check("model_bcd",  32'(bcd),  32'(exp_bcd()));
      check("model_busy", 32'(busy), 32'(m_rem != 0));
      check("model_an",   32'(an),   32'(3'b001 << exp_idx()));
      check("model_seg",  32'(seg),  32'(exp_seg()));
    end
  end

  task automatic wait_an(input logic [2:0] target);
    int n = 0;
    while (an !== target && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_an", 32'(an), 32'(target));
  endtask

  logic [6:0] lead_exp;

  initial begin
    // reset idle
    repeat (2) @(negedge clk);
    run_cmp = 1'b1;
    check("rst_bcd",  32'(bcd),  32'h000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_an",   32'(an),   32'b001);
    check("rst_seg",  32'(seg),  32'b1111110);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // full-scale conversion
    count = 8'd255;
    @(posedge clk);
    @(negedge clk);
    check("fs_busy_e0", 32'(busy), 32'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("fs_busy_e8", 32'(busy), 32'd1);
    check("fs_bcd_e8",  32'(bcd),  32'h000);
    @(posedge clk);
    @(negedge clk);
    check("fs_busy_e9", 32'(busy), 32'd0);
    check("fs_bcd_e9",  32'(bcd),  32'h255);

    // mid-conversion change
    count = 8'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    count = 8'd10;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("mid_bcd9",  32'(bcd),  32'h009);
    check("mid_gap",   32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_restart", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid_bcd10", 32'(bcd), 32'h010);

    // scan sequence
    count = 8'd123;
    repeat (12) @(negedge clk);
    check("scan_bcd", 32'(bcd), 32'h123);
    wait_an(3'b001);
    check("scan_u", 32'(seg), 32'b1111001);
    wait_an(3'b010);
    check("scan_t", 32'(seg), 32'b1101101);
    begin
      int n = 0;
      while (an === 3'b010 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("scan_hold", 32'(n), 32'(SCAN_DIV));
    end
    check("scan_h_an", 32'(an),  32'b100);
    check("scan_h",    32'(seg), 32'b0110000);

    // leading zeros
    count = 8'd7;
    repeat (12) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    lead_exp = 7'b0000000;
`else
    lead_exp = 7'b1111110;
`endif
    wait_an(3'b100);
    check("lz_h", 32'(seg), 32'(lead_exp));
    wait_an(3'b010);
    check("lz_t", 32'(seg), 32'(lead_exp));
    wait_an(3'b001);
    check("lz_u", 32'(seg), 32'b1110000);

    // reset mid-operation
    @(negedge clk);
    count = 8'd200;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_bcd",  32'(bcd),  32'h000);
    check("rmid_an",   32'(an),   32'b001);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rmid_bcd200", 32'(bcd), 32'h200);

    // randomized traffic against the model
    repeat (150) begin
      @(negedge clk);
      count = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 19)) @(negedge clk);
    end
    repeat (15) @(negedge clk);
    run_cmp = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
